bypass_scoreboard: RTL
======================

BYPASS_SCOREBOARD -- requirements
Module: bypass_scoreboard

Interface
REQ-001 SHALL expose parameter NUM_SRC, default 4, number of single-cycle forward sources; index 0 has highest priority.
REQ-002 SHALL expose parameter NUM_RD, default 4, number of operand read ports (two issue slots x two operands).
REQ-003 SHALL expose parameters DW, default 32, data width, and AW, default 5, register address width.
REQ-004 SHALL use one clock and an asynchronous active-low reset, ports named clk and resetn.
REQ-005 Ports:
clk  in  1  clock.
resetn  in  1  async active-low reset.
flush  in  1  pipeline flush; discards pending long-latency ops.
src_wen  in  NUM_SRC  forward source write enables.
src_waddr  in  NUM_SRC x AW  forward source destination registers.
src_wdata  in  NUM_SRC x DW  forward source results.
iss_valid  in  1  long-latency op (load/mul/div) issued this cycle.
iss_waddr  in  AW  its destination register.
cmp_valid  in  1  long-latency result returns this cycle.
cmp_waddr  in  AW  returning destination register.
cmp_wdata  in  DW  returning data.
rd_en  in  NUM_RD  read port active.
rd_addr  in  NUM_RD x AW  source register.
rd_data_rf  in  NUM_RD x DW  register file read data.
rd_data  out  NUM_RD x DW  forwarded operand.
rd_stall  out  NUM_RD  operand not yet available.
stall  out  1  OR of rd_stall.
pend_cnt  out  AW+1  number of registers currently pending.

Function
REQ-006 rd_data[i] SHALL select, combinationally, the first match in order: src 0..NUM_SRC-1, cmp port, late buffer, rd_data_rf[i]; a match requires enable high and address equal.
REQ-007 rd_addr[i]==0 SHALL yield rd_data[i]=0, no stall, regardless of any match.
REQ-008 Scoreboard SHALL hold one pending bit per register; register 0 never sets.
REQ-009 On a clock edge, iss_valid SHALL set pending[iss_waddr]; cmp_valid SHALL clear pending[cmp_waddr]; same address in the same cycle leaves the bit set.
REQ-010 flush SHALL clear all pending bits on the edge and override a simultaneous iss_valid; pend_cnt becomes 0.
REQ-011 rd_stall[i] SHALL be rd_en[i] & addr!=0 & pending[addr] & ~(cmp_valid & cmp_waddr==addr), zero-cycle latency; src matches do not suppress stall.
REQ-012 pend_cnt SHALL increment only on a 0->1 bit transition, decrement only on 1->0, and change by at most 1 per cycle; it never wraps.
REQ-013 cmp_valid for a non-pending register SHALL still forward and latch but SHALL NOT decrement pend_cnt.
REQ-014 rd_en low SHALL force rd_stall[i]=0; rd_data[i] is still computed.

Reset
REQ-015 resetn low SHALL asynchronously clear all pending bits, pend_cnt=0, late-buffer valid=0; outputs then derive from rd_data_rf with stall=0.
REQ-016 Reset mid-operation SHALL discard outstanding ops; a later cmp_valid is treated per REQ-013.

Configuration
REQ-017 With FWD_LATE_BUF_EN defined, a late buffer SHALL register cmp_valid/cmp_waddr/cmp_wdata every edge (flush does not clear it) and serve as a forward source one cycle after return.
REQ-018 Without FWD_LATE_BUF_EN, the late buffer and its priority slot SHALL be absent; selection falls from cmp port to rd_data_rf.

Structure
REQ-019 Shared package SHALL hold DW/AW defaults, the register-index typedef and the zero-register constant.
REQ-020 Per-port selection SHALL live in one sub-module, fwd_sel, instantiated NUM_RD times.

Verification
REQ-021 src0 and src2 both write r5 (0x11, 0x22), read r5 -> rd_data=0x11, no stall.
REQ-022 iss r8; next cycle read r8 -> rd_stall=1, pend_cnt=1; cmp r8 data 0xABCD -> same cycle rd_data=0xABCD, stall=0; next cycle pend_cnt=0.
REQ-023 iss r3 and cmp r3 same cycle (r3 already pending) -> r3 remains pending, pend_cnt unchanged.
REQ-024 pend r1,r2,r4 then flush with iss r6 -> pend_cnt=0, no stalls next cycle.
REQ-025 FWD_LATE_BUF_EN: cmp r9 0x55 with rd_data_rf stale 0x0 -> following cycle read r9 -> 0x55; without macro -> 0x0.
REQ-026 read r0 while src0 writes r0 0xFF and r0 issued -> rd_data=0, stall=0, pend_cnt=0.

Source files
------------

// File: rtl/bypass_scoreboard_pkg.sv
// Shared definitions for the bypass scoreboard: default widths, the
// register-index type and the hard-wired zero register.
package bypass_scoreboard_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;

    typedef logic [AW_DEF-1:0] reg_idx_t;

    // Architectural r0: always reads zero and never becomes pending.
    localparam reg_idx_t ZERO_REG = {AW_DEF{1'b0}};

endpackage : bypass_scoreboard_pkg

// File: rtl/bypass_scoreboard_fwd_sel.sv
// Per-read-port operand selection and stall generation.
// Priority: src 0..NUM_SRC-1, completion port, late buffer (only when
// FWD_LATE_BUF_EN is defined), then register file data.
module fwd_sel
    import bypass_scoreboard_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF
) (
    input  logic                           rd_en,
    input  logic [AW-1:0]                  rd_addr,
    input  logic [DW-1:0]                  rd_data_rf,
    input  logic                           rd_pend,
    input  logic [NUM_SRC-1:0]             src_wen,
    input  logic [NUM_SRC-1:0][AW-1:0]     src_waddr,
    input  logic [NUM_SRC-1:0][DW-1:0]     src_wdata,
    input  logic                           cmp_valid,
    input  logic [AW-1:0]                  cmp_waddr,
    input  logic [DW-1:0]                  cmp_wdata,
`ifdef FWD_LATE_BUF_EN
    input  logic                           late_vld,
    input  logic [AW-1:0]                  late_addr,
    input  logic [DW-1:0]                  late_data,
`endif
    output logic [DW-1:0]                  rd_data,
    output logic                           rd_stall
);

    logic [DW-1:0] sel_data_s;
    logic          addr_zero_s;
    logic          cmp_hit_s;

    // Build the priority chain from lowest to highest priority so the
    // highest-priority match is the last one applied.
    always_comb begin
        addr_zero_s = (rd_addr == AW'(ZERO_REG));
        cmp_hit_s   = cmp_valid && (cmp_waddr == rd_addr);
        sel_data_s  = rd_data_rf;
`ifdef FWD_LATE_BUF_EN
        sel_data_s  = (late_vld && (late_addr == rd_addr)) ? late_data : sel_data_s;
`endif
        sel_data_s  = cmp_hit_s ? cmp_wdata : sel_data_s;
        for (int s = NUM_SRC - 1; s >= 0; s--) begin
            sel_data_s = (src_wen[s] && (src_waddr[s] == rd_addr)) ? src_wdata[s] : sel_data_s;
        end
    end

    // r0 reads as zero; a returning completion releases the stall in the
    // same cycle, forward sources do not.
    assign rd_data  = addr_zero_s ? {DW{1'b0}} : sel_data_s;
    assign rd_stall = rd_en && !addr_zero_s && rd_pend && !cmp_hit_s;

endmodule : fwd_sel

// File: rtl/bypass_scoreboard.sv
// Operand bypass network with a long-latency pending-register scoreboard.
// Optional feature macro: FWD_LATE_BUF_EN adds a one-entry late buffer that
// replays the previous cycle's completion as an extra forward source.
module bypass_scoreboard
    import bypass_scoreboard_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int NUM_RD  = 4,
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           flush,
    input  logic [NUM_SRC-1:0]             src_wen,
    input  logic [NUM_SRC-1:0][AW-1:0]     src_waddr,
    input  logic [NUM_SRC-1:0][DW-1:0]     src_wdata,
    input  logic                           iss_valid,
    input  logic [AW-1:0]                  iss_waddr,
    input  logic                           cmp_valid,
    input  logic [AW-1:0]                  cmp_waddr,
    input  logic [DW-1:0]                  cmp_wdata,
    input  logic [NUM_RD-1:0]              rd_en,
    input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
    input  logic [NUM_RD-1:0][DW-1:0]      rd_data_rf,
    output logic [NUM_RD-1:0][DW-1:0]      rd_data,
    output logic [NUM_RD-1:0]              rd_stall,
    output logic                           stall,
    output logic [AW:0]                    pend_cnt
);

    localparam int NREG = 1 << AW;

    logic [NREG-1:0] pend_r;
    logic [NREG-1:0] pend_nxt_s;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] clr_mask_s;
    logic [AW:0]     pend_cnt_r;
    logic [AW:0]     cnt_nxt_s;
    logic            iss_live_s;
    logic            cmp_live_s;
    logic            set_new_s;
    logic            clr_old_s;
    logic [NUM_RD-1:0] rd_pend_s;

    // Next scoreboard state: issue sets, completion clears (an issue to the
    // same register wins), flush wipes everything; the counter tracks only
    // real bit transitions.
    always_comb begin
        iss_live_s = iss_valid && (iss_waddr != AW'(ZERO_REG));
        cmp_live_s = cmp_valid && (cmp_waddr != AW'(ZERO_REG)) &&
                     !(iss_live_s && (iss_waddr == cmp_waddr));
        set_mask_s = iss_live_s ? ({{(NREG-1){1'b0}}, 1'b1} << iss_waddr) : {NREG{1'b0}};
        clr_mask_s = cmp_live_s ? ({{(NREG-1){1'b0}}, 1'b1} << cmp_waddr) : {NREG{1'b0}};
        set_new_s  = iss_live_s && !pend_r[iss_waddr];
        clr_old_s  = cmp_live_s && pend_r[cmp_waddr];
        pend_nxt_s = pend_r;
        cnt_nxt_s  = pend_cnt_r;
        if (flush) begin
            pend_nxt_s = {NREG{1'b0}};
            cnt_nxt_s  = {(AW+1){1'b0}};
        end else begin
            pend_nxt_s = (pend_r & ~clr_mask_s) | set_mask_s;
            case ({set_new_s, clr_old_s})
                2'b10: begin
                    if (pend_cnt_r != {(AW+1){1'b1}}) begin
                        cnt_nxt_s = pend_cnt_r + {{AW{1'b0}}, 1'b1};
                    end else begin
                        cnt_nxt_s = pend_cnt_r;
                    end
                end
                2'b01: begin
                    if (pend_cnt_r != {(AW+1){1'b0}}) begin
                        cnt_nxt_s = pend_cnt_r - {{AW{1'b0}}, 1'b1};
                    end else begin
                        cnt_nxt_s = pend_cnt_r;
                    end
                end
                default: cnt_nxt_s = pend_cnt_r;
            endcase
        end
    end

    // Scoreboard and pending-count registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_r     <= {NREG{1'b0}};
            pend_cnt_r <= {(AW+1){1'b0}};
        end else begin
            pend_r     <= pend_nxt_s;
            pend_cnt_r <= cnt_nxt_s;
        end
    end

`ifdef FWD_LATE_BUF_EN
    logic          late_vld_r;
    logic [AW-1:0] late_addr_r;
    logic [DW-1:0] late_data_r;

    // Capture the completion port every cycle; flush deliberately leaves it
    // alone because the returned data is architecturally valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            late_vld_r  <= 1'b0;
            late_addr_r <= {AW{1'b0}};
            late_data_r <= {DW{1'b0}};
        end else begin
            late_vld_r  <= cmp_valid;
            late_addr_r <= cmp_waddr;
            late_data_r <= cmp_wdata;
        end
    end
`endif

    // One selector per read port.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        assign rd_pend_s[i] = pend_r[rd_addr[i]];

        fwd_sel #(
            .NUM_SRC (NUM_SRC),
            .DW      (DW),
            .AW      (AW)
        ) u_fwd_sel (
            .rd_en      (rd_en[i]),
            .rd_addr    (rd_addr[i]),
            .rd_data_rf (rd_data_rf[i]),
            .rd_pend    (rd_pend_s[i]),
            .src_wen    (src_wen),
            .src_waddr  (src_waddr),
            .src_wdata  (src_wdata),
            .cmp_valid  (cmp_valid),
            .cmp_waddr  (cmp_waddr),
            .cmp_wdata  (cmp_wdata),
`ifdef FWD_LATE_BUF_EN
            .late_vld   (late_vld_r),
            .late_addr  (late_addr_r),
            .late_data  (late_data_r),
`endif
            .rd_data    (rd_data[i]),
            .rd_stall   (rd_stall[i])
        );
    end

    assign stall    = |rd_stall;
    assign pend_cnt = pend_cnt_r;

endmodule : bypass_scoreboard
